// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the loadable instruction
//                memory (state encoding, default NOP fill bit).
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Two-state controller: accepting a program, or serving fetches.
    typedef enum logic [0:0] {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_t;

    // Default NOP is all-zero; replicated to DATA_W by the top level.
    localparam logic IMEM_NOP_BIT = 1'b0;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/prog_imem_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_imem_if
//  Description : Load-port and fetch-port bundle of the instruction memory.
//                master = program loader / fetch stage, slave = memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_imem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) ();

    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              reload;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_err;
    logic              loaded;
    logic [ADDR_W:0]   word_count;

    modport master (
        output ld_valid, ld_data, ld_last, reload, fetch_req, fetch_addr,
        input  ld_ready, fetch_ready, fetch_valid, fetch_instr, fetch_err,
               loaded, word_count
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, fetch_req, fetch_addr,
        output ld_ready, fetch_ready, fetch_valid, fetch_instr, fetch_err,
               loaded, word_count
    );

endinterface : prog_imem_if
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : imem_ram
//  Description : Simple dual-port RAM, one synchronous write port and one
//                synchronous registered read port. Array is never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    output      logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the load word at the handshake edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: register the addressed word for accepted fetches only.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : imem_ram
`default_nettype wire

// File: rtl/prog_imem.sv
`default_nettype none
// ============================================================================
//  Module      : prog_imem
//  Description : Loadable instruction memory. LOAD state streams a program
//                in from address 0; RUN state serves one fetch per cycle
//                with one-cycle latency and flags out-of-program addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_imem
    import imem_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{IMEM_NOP_BIT}}
) (
    input  wire logic  clk,
    input  wire logic  reset,
    prog_imem_if.slave bus
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

    imem_state_t       state;
    logic [ADDR_W:0]   word_count;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] ram_rdata;

    logic ld_fire;
    logic fetch_fire;
    logic in_range;

    assign ld_fire    = (state == IMEM_LOAD) && bus.ld_valid;
    assign fetch_fire = (state == IMEM_RUN) && bus.fetch_req;
    // Zero-extend so a full memory (count == DEPTH) admits every address.
    assign in_range   = {1'b0, bus.fetch_addr} < word_count;

    imem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (word_count[ADDR_W-1:0]),
        .wdata (bus.ld_data),
        .re    (fetch_fire),
        .raddr (bus.fetch_addr),
        .rdata (ram_rdata)
    );

    // Controller: state, program length and the response flags, which are
    // registered on the same edge as the RAM read so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IMEM_LOAD;
            word_count <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= fetch_fire;
            rsp_err   <= fetch_fire && !in_range;
            case (state)
                IMEM_LOAD: begin
                    if (bus.ld_valid) begin
                        word_count <= word_count + 1'b1;
                        // A full memory ends the load even without ld_last.
                        if (bus.ld_last || (word_count == LAST_SLOT)) begin
                            state <= IMEM_RUN;
                        end
                    end
                end
                IMEM_RUN: begin
                    // A same-cycle fetch was already judged against the old count.
                    if (bus.reload) begin
                        state      <= IMEM_LOAD;
                        word_count <= '0;
                    end
                end
                default: state <= IMEM_LOAD;
            endcase
        end
    end

    assign bus.ld_ready    = (state == IMEM_LOAD);
    assign bus.fetch_ready = (state == IMEM_RUN);
    assign bus.loaded      = (state == IMEM_RUN);
    assign bus.word_count  = word_count;
    assign bus.fetch_valid = rsp_valid;
    assign bus.fetch_err   = rsp_err;
    // RAM output is unreset, so it is only exposed while a response is valid.
    assign bus.fetch_instr = !rsp_valid ? '0 : (rsp_err ? NOP_WORD : ram_rdata);

endmodule : prog_imem
`default_nettype wire

// File: tb/tb_prog_imem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_imem
//  Description : Scoreboard bench for prog_imem: the driver queues expected
//                fetch responses, an independent monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_imem;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic reset;

    prog_imem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    prog_imem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Expected {err, instr} per accepted fetch, in issue order.
    logic [DATA_W:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented response with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && bus.fetch_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got instr %0h with empty scoreboard",
                         bus.fetch_instr);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                check("rsp_instr", 32'(bus.fetch_instr), 32'(e[DATA_W-1:0]));
                check("rsp_err", 32'(bus.fetch_err), 32'(e[DATA_W]));
            end
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [DATA_W-1:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ei,
                         input logic ee, input logic rl);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = a;
        bus.reload     = rl;
        exp_q.push_back({ee, ei});
        tick();
        bus.fetch_req = 1'b0;
        bus.reload    = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.reload     = 1'b0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_ld_ready", 32'(bus.ld_ready), 1);
        check("rst_fetch_ready", 32'(bus.fetch_ready), 0);
        check("rst_loaded", 32'(bus.loaded), 0);
        check("rst_word_count", 32'(bus.word_count), 0);
        check("rst_fetch_valid", 32'(bus.fetch_valid), 0);
        check("rst_fetch_instr", 32'(bus.fetch_instr), 0);

        // Short program terminated by ld_last
        load_word(16'h0001, 1'b0);
        load_word(16'h0010, 1'b0);
        load_word(16'h0100, 1'b1);
        check("p3_loaded", 32'(bus.loaded), 1);
        check("p3_word_count", 32'(bus.word_count), 3);
        check("p3_ld_ready", 32'(bus.ld_ready), 0);
        check("p3_fetch_ready", 32'(bus.fetch_ready), 1);
        fetch(4'd0, 16'h0001, 1'b0, 1'b0);
        fetch(4'd1, 16'h0010, 1'b0, 1'b0);
        fetch(4'd2, 16'h0100, 1'b0, 1'b0);
        fetch(4'd3, 16'h0000, 1'b1, 1'b0);
        fetch(4'd5, 16'h0000, 1'b1, 1'b0);
        repeat (2) tick();
        check("p3_valid_drops", 32'(bus.fetch_valid), 0);

        // Reload with a same-cycle fetch answered from the old program
        fetch(4'd1, 16'h0010, 1'b0, 1'b1);
        check("rl_loaded", 32'(bus.loaded), 0);
        check("rl_word_count", 32'(bus.word_count), 0);
        check("rl_ld_ready", 32'(bus.ld_ready), 1);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 4'd0;
        tick();
        bus.fetch_req = 1'b0;
        check("load_fetch_ignored", 32'(bus.fetch_valid), 0);

        // Full memory forces RUN without ld_last
        for (int i = 0; i < 15; i++) load_word(16'hA000 + 16'(i), 1'b0);
        check("f15_ld_ready", 32'(bus.ld_ready), 1);
        check("f15_word_count", 32'(bus.word_count), 15);
        load_word(16'hA00F, 1'b0);
        check("f16_ld_ready", 32'(bus.ld_ready), 0);
        check("f16_word_count", 32'(bus.word_count), 16);
        check("f16_loaded", 32'(bus.loaded), 1);
        fetch(4'd15, 16'hA00F, 1'b0, 1'b0);
        fetch(4'd0, 16'hA000, 1'b0, 1'b0);
        fetch(4'd3, 16'hA003, 1'b0, 1'b0);

        // ld_valid in RUN must not disturb count or contents
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = i[0];
            bus.ld_data  = 16'h1234;
            tick();
        end
        bus.ld_valid = 1'b0;
        check("run_ld_word_count", 32'(bus.word_count), 16);
        fetch(4'd3, 16'hA003, 1'b0, 1'b0);
        fetch(4'd0, 16'hA000, 1'b0, 1'b0);
        fetch(4'd15, 16'hA00F, 1'b0, 1'b0);
        tick();

        // Reset in the middle of a load
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
        load_word(16'h1111, 1'b0);
        load_word(16'h2222, 1'b0);
        check("mid_word_count", 32'(bus.word_count), 2);
        reset = 1'b1;
        #1;
        check("mr_word_count", 32'(bus.word_count), 0);
        check("mr_ld_ready", 32'(bus.ld_ready), 1);
        check("mr_fetch_valid", 32'(bus.fetch_valid), 0);
        check("mr_fetch_instr", 32'(bus.fetch_instr), 0);
        check("mr_fetch_err", 32'(bus.fetch_err), 0);
        tick();
        reset = 1'b0;
        load_word(16'hBEEF, 1'b1);
        check("beef_word_count", 32'(bus.word_count), 1);
        fetch(4'd0, 16'hBEEF, 1'b0, 1'b0);
        fetch(4'd1, 16'h0000, 1'b1, 1'b0);
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_imem
`default_nettype wire
